mips_multicycle_ctrl: RTL and testbench

//  Moore FSM that sequences a multi-cycle MIPS datapath: shared instr/data memory, IR, A/B/ALUOut regs.

---
 rtl/mips_multicycle_ctrl_if.sv | 35 +++
 rtl/mips_multicycle_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/mips_multicycle_ctrl_if.sv
// rtl/mips_multicycle_ctrl_if.sv - control/status bundle between the multi-cycle controller and its datapath
// master is the controller side, slave is the datapath/memory side.
interface mips_multicycle_ctrl_if;
  logic [5:0] OpCode;
  logic       Zero;
  logic       mem_ready;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemtoReg;
  logic       RegWrite;
  logic       RegDst;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSource;
  logic [3:0] state_o;
  logic       retire;
  logic       trap;

  modport master (
    input  OpCode, Zero, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           RegWrite, RegDst, ALUSrcA, ALUSrcB, ALUOp, PCSource, state_o, retire, trap
  );

  modport slave (
    output OpCode, Zero, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           RegWrite, RegDst, ALUSrcA, ALUSrcB, ALUOp, PCSource, state_o, retire, trap
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - Moore FSM sequencing a multi-cycle MIPS datapath
// Zero is ANDed with PCWriteCond in the datapath, so it is carried but not consumed here.
module mips_multicycle_ctrl #(
  parameter bit         TRAP_ON_ILLEGAL = 1'b1,
  parameter logic [3:0] WAIT_MAX        = 4'd15
) (
  input logic                   Globalclk,
  input logic                   Globalreset,
  mips_multicycle_ctrl_if.master io_bus
);

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,  ST_FETCH  = 4'd1,  ST_DECODE = 4'd2,  ST_MEMADR = 4'd3,
    ST_MEMRD  = 4'd4,  ST_MEMWB  = 4'd5,  ST_MEMWR  = 4'd6,  ST_EXEC   = 4'd7,
    ST_RWB    = 4'd8,  ST_BRANCH = 4'd9,  ST_JUMP   = 4'd10, ST_ADDIEX = 4'd11,
    ST_ADDIWB = 4'd12, ST_TRAP   = 4'd13
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       retire;
    logic       trap;
    logic       is_fetch;
    logic       is_decode;
    logic       is_memwr;
  } ctl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  state_t     r_state;
  logic [3:0] r_wait_cnt;
  ctl_t       r_ctl;

  state_t     w_next;
  logic [3:0] w_wait_next;
  logic       w_timeout;
  logic       w_illegal;
  logic       w_wait_state;

  function automatic ctl_t f_decode(input state_t s);
    ctl_t c;
    c = '0;
    case (s)
      ST_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
        c.is_fetch  = 1'b1;
      end
      ST_DECODE: begin
        c.alu_src_b = 2'b11;
        c.is_decode = 1'b1;
      end
      ST_MEMADR, ST_ADDIEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      ST_MEMRD: begin
        c.iord     = 1'b1;
        c.mem_read = 1'b1;
      end
      ST_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
        c.retire     = 1'b1;
      end
      ST_MEMWR: begin
        c.iord      = 1'b1;
        c.mem_write = 1'b1;
        c.is_memwr  = 1'b1;
      end
      ST_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
      end
      ST_RWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
        c.retire    = 1'b1;
      end
      ST_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = 2'b01;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
        c.retire        = 1'b1;
      end
      ST_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'b10;
        c.retire    = 1'b1;
      end
      ST_ADDIWB: begin
        c.reg_write = 1'b1;
        c.retire    = 1'b1;
      end
      ST_TRAP: c.trap = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    case (io_bus.OpCode)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: w_illegal = 1'b0;
      default:                                       w_illegal = 1'b1;
    endcase
  end

  assign w_wait_state = (r_state == ST_FETCH) || (r_state == ST_MEMRD) || (r_state == ST_MEMWR);
  // A ready arriving on the last allowed cycle still wins over the timeout.
  assign w_timeout    = (WAIT_MAX != 4'd0) && (r_wait_cnt == WAIT_MAX) && !io_bus.mem_ready;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   w_next = ST_FETCH;
      ST_FETCH:  if (io_bus.mem_ready) w_next = ST_DECODE; else if (w_timeout) w_next = ST_TRAP;
      ST_DECODE: begin
        if (w_illegal) begin
          w_next = TRAP_ON_ILLEGAL ? ST_TRAP : ST_FETCH;
        end else begin
          case (io_bus.OpCode)
            OP_LW, OP_SW: w_next = ST_MEMADR;
            OP_RTYPE:     w_next = ST_EXEC;
            OP_BEQ:       w_next = ST_BRANCH;
            OP_J:         w_next = ST_JUMP;
            default:      w_next = ST_ADDIEX;
          endcase
        end
      end
      ST_MEMADR: w_next = (io_bus.OpCode == OP_SW) ? ST_MEMWR : ST_MEMRD;
      ST_MEMRD:  if (io_bus.mem_ready) w_next = ST_MEMWB; else if (w_timeout) w_next = ST_TRAP;
      ST_MEMWR:  if (io_bus.mem_ready) w_next = ST_FETCH; else if (w_timeout) w_next = ST_TRAP;
      ST_EXEC:   w_next = ST_RWB;
      ST_ADDIEX: w_next = ST_ADDIWB;
      ST_MEMWB, ST_RWB, ST_BRANCH, ST_JUMP, ST_ADDIWB: w_next = ST_FETCH;
      ST_TRAP:   w_next = ST_TRAP;
      default:   w_next = ST_TRAP;
    endcase
  end

  always_comb begin
    if (w_next != r_state) begin
      w_wait_next = 4'd0;
    end else if (w_wait_state && !io_bus.mem_ready && (r_wait_cnt != 4'hF)) begin
      w_wait_next = r_wait_cnt + 4'd1;
    end else begin
      w_wait_next = r_wait_cnt;
    end
  end

  // Controls are registered from the next state so they line up with r_state.
  always_ff @(posedge Globalclk or negedge Globalreset) begin
    if (!Globalreset) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= 4'd0;
      r_ctl      <= '0;
    end else begin
      r_state    <= w_next;
      r_wait_cnt <= w_wait_next;
      r_ctl      <= f_decode(w_next);
    end
  end

  assign io_bus.PCWrite     = r_ctl.pc_write | (r_ctl.is_fetch & io_bus.mem_ready);
  assign io_bus.PCWriteCond = r_ctl.pc_write_cond;
  assign io_bus.IorD        = r_ctl.iord;
  assign io_bus.MemRead     = r_ctl.mem_read;
  assign io_bus.MemWrite    = r_ctl.mem_write;
  assign io_bus.IRWrite     = r_ctl.is_fetch & io_bus.mem_ready;
  assign io_bus.MemtoReg    = r_ctl.mem_to_reg;
  assign io_bus.RegWrite    = r_ctl.reg_write;
  assign io_bus.RegDst      = r_ctl.reg_dst;
  assign io_bus.ALUSrcA     = r_ctl.alu_src_a;
  assign io_bus.ALUSrcB     = r_ctl.alu_src_b;
  assign io_bus.ALUOp       = r_ctl.alu_op;
  assign io_bus.PCSource    = r_ctl.pc_source;
  assign io_bus.state_o     = r_state;
  assign io_bus.trap        = r_ctl.trap;
  assign io_bus.retire      = r_ctl.retire
                            | (r_ctl.is_memwr & io_bus.mem_ready)
                            | (r_ctl.is_decode & w_illegal & ~TRAP_ON_ILLEGAL);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - table-driven scoreboard bench for mips_multicycle_ctrl
// DUT a uses default parameters, DUT b uses WAIT_MAX=2 and illegal-as-NOP.
module tb_mips_multicycle_ctrl;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ILL = 6'b111111;

  localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_MEMADR = 4'd3;
  localparam logic [3:0] S_MEMRD = 4'd4, S_MEMWB = 4'd5, S_MEMWR = 4'd6, S_EXEC = 4'd7;
  localparam logic [3:0] S_RWB = 4'd8, S_BRANCH = 4'd9, S_JUMP = 4'd10, S_ADDIEX = 4'd11;
  localparam logic [3:0] S_ADDIWB = 4'd12, S_TRAP = 4'd13;

  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegWrite,RegDst,ALUSrcA,
  //  ALUSrcB[1:0],ALUOp[1:0],PCSource[1:0],retire,trap}
  localparam logic [17:0] C_IDLE     = 18'b0_0_0_0_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] C_FETCH_R  = 18'b1_0_0_1_0_1_0_0_0_0_01_00_00_0_0;
  localparam logic [17:0] C_FETCH_S  = 18'b0_0_0_1_0_0_0_0_0_0_01_00_00_0_0;
  localparam logic [17:0] C_DECODE   = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_0;
  localparam logic [17:0] C_DEC_RET  = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_1_0;
  localparam logic [17:0] C_MEMADR   = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [17:0] C_MEMRD    = 18'b0_0_1_1_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] C_MEMWB    = 18'b0_0_0_0_0_0_1_1_0_0_00_00_00_1_0;
  localparam logic [17:0] C_MEMWR_R  = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_1_0;
  localparam logic [17:0] C_MEMWR_S  = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] C_EXEC     = 18'b0_0_0_0_0_0_0_0_0_1_00_10_00_0_0;
  localparam logic [17:0] C_RWB      = 18'b0_0_0_0_0_0_0_1_1_0_00_00_00_1_0;
  localparam logic [17:0] C_BRANCH   = 18'b0_1_0_0_0_0_0_0_0_1_00_01_01_1_0;
  localparam logic [17:0] C_JUMP     = 18'b1_0_0_0_0_0_0_0_0_0_00_00_10_1_0;
  localparam logic [17:0] C_ADDIWB   = 18'b0_0_0_0_0_0_0_1_0_0_00_00_00_1_0;
  localparam logic [17:0] C_TRAP     = 18'b0_0_0_0_0_0_0_0_0_0_00_00_00_0_1;

  typedef struct {
    logic        sel;
    logic        rst;
    logic        mr;
    logic [5:0]  op;
    logic [3:0]  st;
    logic [17:0] ctl;
  } vec_t;

  typedef struct {
    int          idx;
    logic        sel;
    logic [3:0]  st;
    logic [17:0] ctl;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   checks = 0;
  int   errors = 0;

  vec_t vecs[$];
  exp_t sb[$];

  mips_multicycle_ctrl_if ifa ();
  mips_multicycle_ctrl_if ifb ();

  mips_multicycle_ctrl u_a (
    .Globalclk   (clk),
    .Globalreset (rst_a),
    .io_bus      (ifa)
  );

  mips_multicycle_ctrl #(
    .TRAP_ON_ILLEGAL (1'b0),
    .WAIT_MAX        (4'd2)
  ) u_b (
    .Globalclk   (clk),
    .Globalreset (rst_b),
    .io_bus      (ifb)
  );

  always #5 clk = ~clk;

  logic [17:0] act_a;
  logic [17:0] act_b;
  assign act_a = {ifa.PCWrite, ifa.PCWriteCond, ifa.IorD, ifa.MemRead, ifa.MemWrite, ifa.IRWrite,
                  ifa.MemtoReg, ifa.RegWrite, ifa.RegDst, ifa.ALUSrcA, ifa.ALUSrcB, ifa.ALUOp,
                  ifa.PCSource, ifa.retire, ifa.trap};
  assign act_b = {ifb.PCWrite, ifb.PCWriteCond, ifb.IorD, ifb.MemRead, ifb.MemWrite, ifb.IRWrite,
                  ifb.MemtoReg, ifb.RegWrite, ifb.RegDst, ifb.ALUSrcA, ifb.ALUSrcB, ifb.ALUOp,
                  ifb.PCSource, ifb.retire, ifb.trap};

  always @(negedge clk) begin : chk
    exp_t        e;
    logic [3:0]  st;
    logic [17:0] ctl;
    if (sb.size() != 0) begin
      e   = sb.pop_front();
      st  = e.sel ? ifb.state_o : ifa.state_o;
      ctl = e.sel ? act_b : act_a;
      checks++;
      if (st !== e.st) begin
        errors++;
        $display("FAIL row%0d dut%0d state actual=%0d required=%0d", e.idx, e.sel, st, e.st);
      end
      checks++;
      if (ctl !== e.ctl) begin
        errors++;
        $display("FAIL row%0d dut%0d controls actual=%b required=%b", e.idx, e.sel, ctl, e.ctl);
      end
    end
  end

  task automatic add(input logic sel, input logic rst, input logic mr, input logic [5:0] op,
                     input logic [3:0] st, input logic [17:0] ctl);
    vec_t v;
    v.sel = sel; v.rst = rst; v.mr = mr; v.op = op; v.st = st; v.ctl = ctl;
    vecs.push_back(v);
  endtask

  initial begin
    exp_t e;
    rst_a = 1'b0; rst_b = 1'b0;
    ifa.mem_ready = 1'b0; ifa.OpCode = OP_R; ifa.Zero = 1'b0;
    ifb.mem_ready = 1'b0; ifb.OpCode = OP_R; ifb.Zero = 1'b0;

    // DUT a: reset release then two back-to-back R-type instructions
    add(0, 0, 1, OP_R, S_IDLE, C_IDLE);
    add(0, 1, 1, OP_R, S_IDLE, C_IDLE);
    for (int k = 0; k < 2; k++) begin
      add(0, 1, 1, OP_R, S_FETCH, C_FETCH_R);
      add(0, 1, 1, OP_R, S_DECODE, C_DECODE);
      add(0, 1, 1, OP_R, S_EXEC, C_EXEC);
      add(0, 1, 1, OP_R, S_RWB, C_RWB);
    end
    // lw with three stalled MEMRD cycles
    add(0, 1, 1, OP_LW, S_FETCH, C_FETCH_R);
    add(0, 1, 1, OP_LW, S_DECODE, C_DECODE);
    add(0, 1, 1, OP_LW, S_MEMADR, C_MEMADR);
    for (int k = 0; k < 3; k++) add(0, 1, 0, OP_LW, S_MEMRD, C_MEMRD);
    add(0, 1, 1, OP_LW, S_MEMRD, C_MEMRD);
    add(0, 1, 1, OP_LW, S_MEMWB, C_MEMWB);
    // sw zero wait, then sw with two stalled MEMWR cycles
    add(0, 1, 1, OP_SW, S_FETCH, C_FETCH_R);
    add(0, 1, 1, OP_SW, S_DECODE, C_DECODE);
    add(0, 1, 1, OP_SW, S_MEMADR, C_MEMADR);
    add(0, 1, 1, OP_SW, S_MEMWR, C_MEMWR_R);
    add(0, 1, 1, OP_SW, S_FETCH, C_FETCH_R);
    add(0, 1, 1, OP_SW, S_DECODE, C_DECODE);
    add(0, 1, 1, OP_SW, S_MEMADR, C_MEMADR);
    add(0, 1, 0, OP_SW, S_MEMWR, C_MEMWR_S);
    add(0, 1, 0, OP_SW, S_MEMWR, C_MEMWR_S);
    add(0, 1, 1, OP_SW, S_MEMWR, C_MEMWR_R);
    // beq, j, addi
    add(0, 1, 1, OP_BEQ, S_FETCH, C_FETCH_R);
    add(0, 1, 1, OP_BEQ, S_DECODE, C_DECODE);
    add(0, 1, 1, OP_BEQ, S_BRANCH, C_BRANCH);
    add(0, 1, 1, OP_J, S_FETCH, C_FETCH_R);
    add(0, 1, 1, OP_J, S_DECODE, C_DECODE);
    add(0, 1, 1, OP_J, S_JUMP, C_JUMP);
    add(0, 1, 1, OP_ADDI, S_FETCH, C_FETCH_R);
    add(0, 1, 1, OP_ADDI, S_DECODE, C_DECODE);
    add(0, 1, 1, OP_ADDI, S_ADDIEX, C_MEMADR);
    add(0, 1, 1, OP_ADDI, S_ADDIWB, C_ADDIWB);
    // stalled fetch, then reset asserted mid-store while memory signals ready
    add(0, 1, 0, OP_SW, S_FETCH, C_FETCH_S);
    add(0, 1, 0, OP_SW, S_FETCH, C_FETCH_S);
    add(0, 1, 1, OP_SW, S_FETCH, C_FETCH_R);
    add(0, 1, 1, OP_SW, S_DECODE, C_DECODE);
    add(0, 1, 1, OP_SW, S_MEMADR, C_MEMADR);
    add(0, 1, 0, OP_SW, S_MEMWR, C_MEMWR_S);
    add(0, 0, 1, OP_SW, S_IDLE, C_IDLE);
    add(0, 1, 1, OP_ILL, S_IDLE, C_IDLE);
    // illegal opcode traps and sticks until reset
    add(0, 1, 1, OP_ILL, S_FETCH, C_FETCH_R);
    add(0, 1, 1, OP_ILL, S_DECODE, C_DECODE);
    for (int k = 0; k < 20; k++) add(0, 1, 1'(k % 2), OP_R, S_TRAP, C_TRAP);
    add(0, 0, 1, OP_R, S_IDLE, C_IDLE);
    add(0, 1, 1, OP_R, S_IDLE, C_IDLE);
    add(0, 1, 1, OP_R, S_FETCH, C_FETCH_R);

    // DUT b: fetch timeout after the third stalled cycle
    add(1, 0, 0, OP_R, S_IDLE, C_IDLE);
    add(1, 1, 0, OP_R, S_IDLE, C_IDLE);
    for (int k = 0; k < 3; k++) add(1, 1, 0, OP_R, S_FETCH, C_FETCH_S);
    add(1, 1, 1, OP_R, S_TRAP, C_TRAP);
    add(1, 1, 1, OP_R, S_TRAP, C_TRAP);
    // ready on the deadline cycle wins
    add(1, 0, 0, OP_R, S_IDLE, C_IDLE);
    add(1, 1, 0, OP_R, S_IDLE, C_IDLE);
    add(1, 1, 0, OP_R, S_FETCH, C_FETCH_S);
    add(1, 1, 0, OP_R, S_FETCH, C_FETCH_S);
    add(1, 1, 1, OP_R, S_FETCH, C_FETCH_R);
    add(1, 1, 1, OP_R, S_DECODE, C_DECODE);
    add(1, 1, 1, OP_R, S_EXEC, C_EXEC);
    add(1, 1, 1, OP_R, S_RWB, C_RWB);
    // wait counter must clear between FETCH and MEMRD stalls
    add(1, 1, 0, OP_LW, S_FETCH, C_FETCH_S);
    add(1, 1, 0, OP_LW, S_FETCH, C_FETCH_S);
    add(1, 1, 1, OP_LW, S_FETCH, C_FETCH_R);
    add(1, 1, 1, OP_LW, S_DECODE, C_DECODE);
    add(1, 1, 1, OP_LW, S_MEMADR, C_MEMADR);
    add(1, 1, 0, OP_LW, S_MEMRD, C_MEMRD);
    add(1, 1, 0, OP_LW, S_MEMRD, C_MEMRD);
    add(1, 1, 1, OP_LW, S_MEMRD, C_MEMRD);
    add(1, 1, 1, OP_LW, S_MEMWB, C_MEMWB);
    // illegal opcode behaves as a retiring NOP
    add(1, 1, 1, OP_ILL, S_FETCH, C_FETCH_R);
    add(1, 1, 1, OP_ILL, S_DECODE, C_DEC_RET);
    add(1, 1, 1, OP_R, S_FETCH, C_FETCH_R);
    add(1, 1, 1, OP_R, S_DECODE, C_DECODE);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      if (vecs[i].sel) begin
        rst_b = vecs[i].rst; ifb.mem_ready = vecs[i].mr; ifb.OpCode = vecs[i].op;
      end else begin
        rst_a = vecs[i].rst; ifa.mem_ready = vecs[i].mr; ifa.OpCode = vecs[i].op;
      end
      ifa.Zero = 1'($urandom_range(0, 1));
      ifb.Zero = 1'($urandom_range(0, 1));
      e.idx = i; e.sel = vecs[i].sel; e.st = vecs[i].st; e.ctl = vecs[i].ctl;
      sb.push_back(e);
    end
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
